// File: rtl/tech_regfile_arb.sv
// Two-port arbiter in front of a single-port register-file macro.
// Optionally zero-fills the macro after reset, then grants one request per cycle with round-robin ties.
module tech_regfile_arb #(
  parameter int BIT_WIDTH      = 128,
  parameter int WORD_DEPTH     = 64,
  parameter bit CLEAR_ON_RESET = 1'b1,
  localparam int AW            = $clog2(WORD_DEPTH)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  // requester 0
  input  logic                 req0_valid_i,
  output logic                 req0_ready_o,
  input  logic                 req0_we_i,
  input  logic [AW-1:0]        req0_addr_i,
  input  logic [BIT_WIDTH-1:0] req0_dat_i,
  output logic                 rsp0_valid_o,
  input  logic                 rsp0_ready_i,
  output logic [BIT_WIDTH-1:0] rsp0_dat_o,
  // requester 1
  input  logic                 req1_valid_i,
  output logic                 req1_ready_o,
  input  logic                 req1_we_i,
  input  logic [AW-1:0]        req1_addr_i,
  input  logic [BIT_WIDTH-1:0] req1_dat_i,
  output logic                 rsp1_valid_o,
  input  logic                 rsp1_ready_i,
  output logic [BIT_WIDTH-1:0] rsp1_dat_o,
  // macro side
  output logic                 rf_en_o,
  output logic                 rf_wen_o,
  output logic [AW-1:0]        rf_addr_o,
  output logic [BIT_WIDTH-1:0] rf_dat_o,
  input  logic [BIT_WIDTH-1:0] rf_dat_i,
  output logic                 init_done_o
);

  // Handshake: a request transfers when reqN_valid_i && reqN_ready_o in the same cycle;
  // a response transfers when rspN_valid_o && rspN_ready_i, and valid drops the next cycle.

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_INIT  = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

  localparam logic [AW-1:0] INIT_LAST = AW'(WORD_DEPTH - 1);

  state_e               state_q;
  logic [AW-1:0]        init_cnt_q;
  logic                 init_done_q;
  logic                 last_q;
  logic                 last_d;
  logic [1:0]           inflight_q;
  logic [1:0]           inflight_d;
  logic [1:0]           rsp_valid_q;
  logic [1:0]           rsp_valid_d;
  logic [BIT_WIDTH-1:0] rsp_dat_q [2];

  logic                 run;
  logic [1:0]           req_valid;
  logic [1:0]           req_we;
  logic [1:0]           rsp_ready;
  logic [1:0]           elig;
  logic [1:0]           gnt;
  logic                 hs;
  logic                 sel_we;
  logic [AW-1:0]        sel_addr;
  logic [BIT_WIDTH-1:0] sel_dat;

  assign run       = (state_q == ST_RUN);
  assign req_valid = {req1_valid_i, req0_valid_i};
  assign req_we    = {req1_we_i, req0_we_i};
  assign rsp_ready = {rsp1_ready_i, rsp0_ready_i};

  // A read may issue once the previous response is gone or is being consumed this cycle.
  always_comb begin
    elig = 2'b00;
    for (int p = 0; p < 2; p++) begin
      elig[p] = run & req_valid[p] &
                (req_we[p] | (~inflight_q[p] & (~rsp_valid_q[p] | rsp_ready[p])));
    end
  end

  always_comb begin
    gnt = elig;
    if (elig == 2'b11) begin
      gnt = last_q ? 2'b01 : 2'b10;
    end
  end

  assign hs       = |gnt;
  assign sel_we   = gnt[1] ? req1_we_i   : req0_we_i;
  assign sel_addr = gnt[1] ? req1_addr_i : req0_addr_i;
  assign sel_dat  = gnt[1] ? req1_dat_i  : req0_dat_i;

  assign last_d     = hs ? gnt[1] : last_q;
  assign inflight_d = gnt & ~req_we;

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    for (int p = 0; p < 2; p++) begin
      if (inflight_q[p]) begin
        rsp_valid_d[p] = 1'b1;
      end else if (rsp_valid_q[p] && rsp_ready[p]) begin
        rsp_valid_d[p] = 1'b0;
      end
    end
  end

  always_comb begin
    rf_en_o   = 1'b1;
    rf_wen_o  = 1'b1;
    rf_addr_o = '0;
    rf_dat_o  = '0;
    if (state_q == ST_INIT) begin
      rf_en_o   = 1'b0;
      rf_wen_o  = 1'b0;
      rf_addr_o = init_cnt_q;
    end else if (hs) begin
      rf_en_o   = 1'b0;
      rf_wen_o  = ~sel_we;
      rf_addr_o = sel_addr;
      rf_dat_o  = sel_we ? sel_dat : '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_RESET;
      init_cnt_q   <= '0;
      init_done_q  <= 1'b0;
      last_q       <= 1'b1;
      inflight_q   <= 2'b00;
      rsp_valid_q  <= 2'b00;
      rsp_dat_q[0] <= '0;
      rsp_dat_q[1] <= '0;
    end else begin
      case (state_q)
        ST_RESET: begin
          init_cnt_q <= '0;
          if (CLEAR_ON_RESET) begin
            state_q <= ST_INIT;
          end else begin
            state_q     <= ST_RUN;
            init_done_q <= 1'b1;
          end
        end
        ST_INIT: begin
          if (init_cnt_q == INIT_LAST) begin
            state_q     <= ST_RUN;
            init_done_q <= 1'b1;
          end else begin
            init_cnt_q <= init_cnt_q + 1'b1;
          end
        end
        ST_RUN: begin
          inflight_q  <= inflight_d;
          rsp_valid_q <= rsp_valid_d;
          last_q      <= last_d;
          // Macro read data is valid the cycle after the read handshake.
          for (int p = 0; p < 2; p++) begin
            if (inflight_q[p]) begin
              rsp_dat_q[p] <= rf_dat_i;
            end
          end
        end
        default: state_q <= ST_RESET;
      endcase
    end
  end

  assign req0_ready_o = gnt[0];
  assign req1_ready_o = gnt[1];
  assign rsp0_valid_o = rsp_valid_q[0];
  assign rsp1_valid_o = rsp_valid_q[1];
  assign rsp0_dat_o   = rsp_dat_q[0];
  assign rsp1_dat_o   = rsp_dat_q[1];
  assign init_done_o  = init_done_q;

endmodule
